// File: rtl/sdk_print_uplink.sv
// Core-to-host print channel: buffers core bytes in a small FIFO and frames them into
// {8'hA5, N} + payload-word packets on the shared SDK FIFO write port.
module sdk_print_uplink #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned MAX_BURST     = 8,
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic                SDK_CLK,
  input  logic                SDK_RSTN,
  input  logic                tf_push_i,
  input  logic [7:0]          print_data_i,
  output logic                tx_req_o,
  input  logic                tx_grant_i,
  output logic                SDK_FIFO_WR,
  output logic [15:0]         SDK_FIFO_DO,
  input  logic                SDK_FIFO_Full,
  output logic                SDK_Interrupt,
  output logic                overflow_o,
  output logic [DEPTH_LOG2:0] level_o
);

  localparam int unsigned Depth  = 2 ** DEPTH_LOG2;
  localparam int unsigned TimerW = $clog2(FLUSH_TIMEOUT + 1);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   lvl_t;
  typedef logic [TimerW-1:0]     tmr_t;

  localparam lvl_t DepthL   = lvl_t'(Depth);
  localparam lvl_t BurstL   = lvl_t'(MAX_BURST);
  localparam tmr_t TimeoutL = tmr_t'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  mem_q [Depth];
  ptr_t        wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  lvl_t        level_q, level_d;
  tmr_t        timer_q, timer_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] do_q, do_d;
  logic        ovf_q;
  logic [1:0]  pop_cnt;
  logic        push_ok;
  logic        wr;

  assign rd_ptr_nx = rd_ptr_q + ptr_t'(1);
  assign wr = ((state_q == StHdr) || (state_q == StData)) && tx_grant_i && !SDK_FIFO_Full;

  // rem_q counts payload bytes not yet written, including the word currently in do_q.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    rem_d   = rem_q;
    do_d    = do_q;
    pop_cnt = 2'd0;
    case (state_q)
      StIdle: begin
        if ((level_q >= BurstL) || ((level_q != '0) && (timer_q == TimeoutL))) begin
          n_d     = (level_q >= BurstL) ? 8'(MAX_BURST) : 8'(level_q);
          do_d    = {8'hA5, n_d};
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (wr) begin
          rem_d   = n_q;
          pop_cnt = (n_q == 8'd1) ? 2'd1 : 2'd2;
          state_d = StData;
        end
      end
      StData: begin
        if (wr) begin
          rem_d = rem_q - ((rem_q >= 8'd2) ? 8'd2 : 8'd1);
          if (rem_d == 8'd0) begin
            state_d = StDone;
          end else begin
            pop_cnt = (rem_d == 8'd1) ? 2'd1 : 2'd2;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (pop_cnt != 2'd0) begin
      do_d = {mem_q[rd_ptr_q], (pop_cnt == 2'd2) ? mem_q[rd_ptr_nx] : 8'h00};
    end
  end

  // A push into a full FIFO still lands if a word load frees space in the same cycle.
  always_comb begin
    push_ok = tf_push_i && ((level_q != DepthL) || (pop_cnt != 2'd0));
    level_d = level_q + lvl_t'(push_ok) - lvl_t'(pop_cnt);
    if (tf_push_i || (level_q == '0)) begin
      timer_d = '0;
    end else if (timer_q != TimeoutL) begin
      timer_d = timer_q + tmr_t'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge SDK_CLK) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= print_data_i;
    end
  end

  always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
    if (!SDK_RSTN) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      timer_q  <= '0;
      n_q      <= '0;
      rem_q    <= '0;
      do_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      timer_q  <= timer_d;
      n_q      <= n_d;
      rem_q    <= rem_d;
      do_q     <= do_d;
      rd_ptr_q <= rd_ptr_q + ptr_t'(pop_cnt);
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      end
      if (tf_push_i && !push_ok) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign tx_req_o      = (state_q == StHdr) || (state_q == StData);
  assign SDK_FIFO_WR   = wr;
  assign SDK_FIFO_DO   = do_q;
  assign SDK_Interrupt = (state_q == StDone);
  assign overflow_o    = ovf_q;
  assign level_o       = level_q;

endmodule
